gf2_solution_search: RTL and testbench
======================================

Name: gf2_solution_search

Overview:
- Enumerates every solution of an already-reduced GF(2) linear system, given a particular solution x0 and one null-space basis vector per free variable.
- Walks the 2^f solution space in Gray-code order, so each new solution costs exactly one XOR.
- Tracks the minimum-Hamming-weight solution (minimum button presses).
- Depending on mode, streams either every solution or only the minimum one over AXI-Stream.
- Sits between the GF(2) elimination stage and the answer accumulator; successor to the fixed enumerate-only stage.

Parameters:
- MAX_VARS, 16, maximum number of variables (solution vector width).
- MAX_FREE, 8, maximum number of free variables (basis vectors).
- AXI_DATA_WIDTH, 8, stream beat width.
- MAX_VARS_W, clog2(MAX_VARS+1), width of variable counts and weights.
- MAX_FREE_W, clog2(MAX_FREE+1), width of free-variable counts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = stream all solutions, 1 = stream minimum-weight solution only.
- vars  in  MAX_VARS_W  active variable count, 1..MAX_VARS.
- free_count  in  MAX_FREE_W  number of valid basis vectors.
- x0  in  MAX_VARS  particular solution.
- bases  in  MAX_FREE x MAX_VARS  null-space basis vectors; entry i is valid for i < free_count.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle pulse at completion.
- err  out  1  free_count > MAX_FREE; held until next start.
- min_weight  out  MAX_VARS_W  minimum popcount found.
- min_solution  out  MAX_VARS  earliest solution achieving min_weight.
- solution_count  out  MAX_FREE+1  number of solutions evaluated.
- solution_stream  axi_stream_if.master  serialized solution vectors.

Behaviour:
- Reset: state IDLE; busy, done, err = 0; min_weight = all-ones; min_solution = 0; solution_count = 0; tvalid = 0.
- Reset mid-operation: same reset values, applied on the next edge; no partial vector is resumed.
- IDLE: on start, snapshot vars, free_count, x0, bases and mode into registers. Clear min_weight to all-ones and solution_count to 0; set x_cur = x0, k = 0.
  - If free_count > MAX_FREE: set err = 1 and go to DONE; no beats are emitted.
  - Otherwise go to EVAL.
- Inputs are ignored after the snapshot. start is ignored outside IDLE.
- Masking: bits at or above vars are masked to 0 in x_cur, in the weight and on the stream.
- EVAL (one cycle per solution):
  - w = popcount(x_cur masked); solution_count increments.
  - If w < min_weight, update min_weight and min_solution. On a tie, keep the earlier solution.
  - mode 0: go to EMIT.
  - mode 1: if k == 2^free_count - 1, go to EMIT_MIN. Otherwise x_cur ^= bases[ctz(k+1)], k++, stay in EVAL.
- EMIT (mode 0): serialize x_cur. When the serializer completes:
  - last solution: go to DONE;
  - otherwise apply the Gray step and return to EVAL.
- EMIT_MIN: serialize min_solution once, then go to DONE.
- DONE: done = 1 for one cycle, busy = 0, return to IDLE. Results hold until the next accepted start.
- free_count = 0: exactly one solution (x0).
- Stream format:
  - Each vector is ceil(vars / AXI_DATA_WIDTH) beats, least-significant bits first; unused high bits are 0.
  - tlast is asserted only on the final beat of the final emitted vector.
  - tdata and tlast are stable while tvalid && !tready; tvalid never drops before the handshake completes.
- Throughput: mode 1 needs 2^f EVAL cycles plus one emission; mode 0 is bounded by the stream.

Decomposition:
- Package gf2_search_pkg holds the state_t enum (IDLE, EVAL, EMIT, EMIT_MIN, DONE) and the mode encoding constants.
- Sub-module solution_serializer:
  - inputs: start, vector, length, last flag;
  - outputs: the beat stream and a ready pulse;
  - reusable by other solver stages.
- Popcount and ctz are functions in the package, not modules.

Test Plan:
- vars=5, free_count=0, x0=10110b, mode 0, tready=1 -> one beat 0x16 with tlast; min_weight=3, solution_count=1, done pulse.
- vars=4, free=2, x0=0001b, bases[0]=0011b, bases[1]=0100b, mode 0 -> beats 0x01, 0x02, 0x06, 0x05; tlast on 0x05 only; min_weight=1, min_solution=0001b, solution_count=4.
- Same inputs, mode 1 -> exactly one beat 0x01 with tlast; done 6 cycles after start with tready=1.
- vars=12, AXI_DATA_WIDTH=8, free=1, x0=0xABC, bases[0]=0x00F, random tready -> beats 0xBC, 0x0A, 0xB3, 0x0A; data stable under backpressure; tlast on beat 4 only.
- free_count=9 with MAX_FREE=8 -> err=1, done pulse, zero beats, min_weight stays all-ones.
- rst_n low during the second beat of EMIT -> tvalid=0 and busy=0 next cycle; a new start reproduces the full sequence from the first solution.

Source files
------------

// File: rtl/gf2_solution_search_pkg.sv
// Shared types and bit-counting helpers for the GF(2) solution search stage.
package gf2_search_pkg;

   typedef enum logic [2:0] {IDLE, EVAL, EMIT, EMIT_MIN, DONE} state_t;

   localparam logic MODE_ALL = 1'b0;
   localparam logic MODE_MIN = 1'b1;

   function automatic int popcount(input logic [63:0] v);
      popcount = 0;
      for (int i = 0; i < 64; i++) popcount += int'(v[i]);
   endfunction

   // Index of the lowest set bit; callers guarantee v != 0.
   function automatic int ctz(input logic [63:0] v);
      ctz = 0;
      for (int i = 63; i >= 0; i--) if (v[i]) ctz = i;
   endfunction

   function automatic logic [63:0] low_mask(input int n);
      for (int i = 0; i < 64; i++) low_mask[i] = (i < n);
   endfunction

endpackage

// File: rtl/gf2_solution_search_if.sv
// AXI-Stream beat channel used for serialized solution vectors.
interface axi_stream_if #(parameter int DATA_WIDTH = 8);
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [DATA_WIDTH-1:0] tdata;

   modport master (output tvalid, tdata, tlast, input tready);
   modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/gf2_solution_search_serializer.sv
// Splits one vector into LSB-first stream beats; ready pulses on the final handshake.
module solution_serializer #(
   parameter int VEC_W  = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [VEC_W-1:0] vector,
   input  logic [LEN_W-1:0] length,
   input  logic             last,
   axi_stream_if.master     beat_stream,
   output logic             ready
);
   localparam int NB   = (VEC_W + DATA_W - 1) / DATA_W;
   localparam int SH_W = NB * DATA_W;
   localparam int BC_W = $clog2(NB + 1);

   logic [SH_W-1:0] shreg;
   logic [BC_W-1:0] beats, beats_init;
   logic            valid, last_r, fire;

   // A zero length still produces one all-zero beat so the handshake always completes.
   assign beats_init = (length == '0) ? BC_W'(1)
                                      : BC_W'((int'(length) + DATA_W - 1) / DATA_W);
   assign fire  = valid && beat_stream.tready;
   assign ready = fire && (beats == BC_W'(1));

   assign beat_stream.tvalid = valid;
   assign beat_stream.tdata  = shreg[DATA_W-1:0];
   assign beat_stream.tlast  = last_r && (beats == BC_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg  <= '0;
         beats  <= '0;
         valid  <= 1'b0;
         last_r <= 1'b0;
      end else if (start) begin
         shreg  <= SH_W'(vector);
         beats  <= beats_init;
         valid  <= 1'b1;
         last_r <= last;
      end else if (fire) begin
         shreg <= shreg >> DATA_W;
         beats <= beats - BC_W'(1);
         if (beats == BC_W'(1)) valid <= 1'b0;
      end
   end
endmodule

// File: rtl/gf2_solution_search.sv
// Gray-code walk over x0 + span(bases), tracking the minimum-weight solution and streaming results.
module gf2_solution_search
   import gf2_search_pkg::*;
#(
   parameter int MAX_VARS       = 16,
   parameter int MAX_FREE       = 8,
   parameter int AXI_DATA_WIDTH = 8,
   parameter int MAX_VARS_W     = $clog2(MAX_VARS + 1),
   parameter int MAX_FREE_W     = $clog2(MAX_FREE + 1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               mode,
   input  logic [MAX_VARS_W-1:0]              vars,
   input  logic [MAX_FREE_W-1:0]              free_count,
   input  logic [MAX_VARS-1:0]                x0,
   input  logic [MAX_FREE-1:0][MAX_VARS-1:0]  bases,
   output logic                               busy,
   output logic                               done,
   output logic                               err,
   output logic [MAX_VARS_W-1:0]              min_weight,
   output logic [MAX_VARS-1:0]                min_solution,
   output logic [MAX_FREE:0]                  solution_count,
   axi_stream_if.master                       solution_stream
);
   localparam int IDX_W = (MAX_FREE > 1) ? $clog2(MAX_FREE) : 1;

   state_t                              state, state_nx;
   logic                                mode_r;
   logic [MAX_VARS_W-1:0]               vars_r, w;
   logic [MAX_FREE_W-1:0]               fc_r;
   logic [MAX_FREE-1:0][MAX_VARS-1:0]   bases_r;
   logic [MAX_VARS-1:0]                 x_cur, mask, mask_in, min_nx, ser_vec;
   logic [MAX_FREE:0]                   k, last_k;
   logic [IDX_W-1:0]                    flip_idx;
   logic                                better, is_last, eval_en, step_en;
   logic                                ser_start, ser_last, ser_ready;

   assign mask_in  = MAX_VARS'(low_mask(int'(vars)));
   assign mask     = MAX_VARS'(low_mask(int'(vars_r)));
   assign last_k   = (MAX_FREE+1)'((64'd1 << fc_r) - 64'd1);
   assign is_last  = (k == last_k);
   assign flip_idx = IDX_W'(ctz(64'(k + 1'b1)));
   assign w        = MAX_VARS_W'(popcount(64'(x_cur)));
   assign better   = (w < min_weight);
   assign min_nx   = better ? x_cur : min_solution;
   assign busy     = (state == EVAL) || (state == EMIT) || (state == EMIT_MIN);
   assign done     = (state == DONE);

   always_comb begin
      state_nx  = state;
      eval_en   = 1'b0;
      step_en   = 1'b0;
      ser_start = 1'b0;
      ser_vec   = x_cur;
      ser_last  = 1'b0;
      case (state)
         IDLE: if (start) state_nx = (int'(free_count) > MAX_FREE) ? DONE : EVAL;
         EVAL: begin
            eval_en = 1'b1;
            if (mode_r == MODE_ALL) begin
               ser_start = 1'b1;
               ser_last  = is_last;
               state_nx  = EMIT;
            end else if (is_last) begin
               // Hand the serializer the minimum including this cycle's candidate.
               ser_start = 1'b1;
               ser_vec   = min_nx;
               ser_last  = 1'b1;
               state_nx  = EMIT_MIN;
            end else begin
               step_en = 1'b1;
            end
         end
         EMIT: if (ser_ready) begin
            if (is_last) state_nx = DONE;
            else begin
               step_en  = 1'b1;
               state_nx = EVAL;
            end
         end
         EMIT_MIN: if (ser_ready) state_nx = DONE;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         err            <= 1'b0;
         min_weight     <= '1;
         min_solution   <= '0;
         solution_count <= '0;
         mode_r         <= MODE_ALL;
         vars_r         <= '0;
         fc_r           <= '0;
         bases_r        <= '0;
         x_cur          <= '0;
         k              <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            err            <= (int'(free_count) > MAX_FREE);
            min_weight     <= '1;
            solution_count <= '0;
            mode_r         <= mode;
            vars_r         <= vars;
            fc_r           <= free_count;
            bases_r        <= bases;
            x_cur          <= x0 & mask_in;
            k              <= '0;
         end
         if (eval_en) begin
            solution_count <= solution_count + 1'b1;
            if (better) begin
               min_weight   <= w;
               min_solution <= x_cur;
            end
         end
         if (step_en) begin
            x_cur <= x_cur ^ (bases_r[flip_idx] & mask);
            k     <= k + 1'b1;
         end
      end
   end

   solution_serializer #(
      .VEC_W (MAX_VARS),
      .DATA_W(AXI_DATA_WIDTH),
      .LEN_W (MAX_VARS_W)
   ) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (ser_start),
      .vector     (ser_vec),
      .length     (vars_r),
      .last       (ser_last),
      .beat_stream(solution_stream),
      .ready      (ser_ready)
   );
endmodule

// File: tb/tb_gf2_solution_search.sv
// Directed and randomized checks of gf2_solution_search against a closed-form Gray-code model.
module tb_gf2_solution_search;
   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic [4:0]        vars = 5'd1;
   logic [3:0]        free_count = 4'd0;
   logic [15:0]       x0 = '0;
   logic [7:0][15:0]  bases = '0;
   logic              busy, done, err;
   logic [4:0]        min_weight;
   logic [15:0]       min_solution;
   logic [8:0]        solution_count;

   bit                rand_ready = 1'b0;
   int                n_assert = 0;
   int                n_fail = 0;
   logic [8:0]        got[$];
   logic              prev_stall = 1'b0;
   logic [8:0]        prev_beat = '0;

   axi_stream_if #(.DATA_WIDTH(8)) s_if();

   gf2_solution_search dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .mode           (mode),
      .vars           (vars),
      .free_count     (free_count),
      .x0             (x0),
      .bases          (bases),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .min_weight     (min_weight),
      .min_solution   (min_solution),
      .solution_count (solution_count),
      .solution_stream(s_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial s_if.tready = 1'b1;
   always @(posedge clk) begin
      #1;
      s_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Handshakes are judged half a cycle ahead of the edge that completes them.
   always @(negedge clk) begin
      if (!rst_n) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("stable.tvalid", 64'(s_if.tvalid), 64'(1));
            chk("stable.beat", 64'({s_if.tlast, s_if.tdata}), 64'(prev_beat));
         end
         if (s_if.tvalid && s_if.tready) got.push_back({s_if.tlast, s_if.tdata});
         prev_stall = s_if.tvalid && !s_if.tready;
         prev_beat  = {s_if.tlast, s_if.tdata};
      end
   end

   task automatic run_case(input string tag, input int nv, input int fc, input logic [15:0] x,
                           input logic [7:0][15:0] b, input logic md, input bit rr, input int exp_lat);
      logic [8:0]  exp_q[$];
      logic [15:0] msk, s, best;
      int          nvec, nb, bw, lat;
      bit          seen;
      msk = '0;
      for (int i = 0; i < 16; i++) if (i < nv) msk[i] = 1'b1;
      bw = 31; best = '0; nvec = 0; nb = (nv + 7) / 8;
      if (fc <= 8) begin
         nvec = 1 << fc;
         for (int kk = 0; kk < nvec; kk++) begin
            int g;
            g = kk ^ (kk >> 1);
            s = x;
            for (int i = 0; i < fc; i++) if (g[i]) s ^= b[i];
            s &= msk;
            if ($countones(s) < bw) begin bw = $countones(s); best = s; end
            if (!md) for (int j = 0; j < nb; j++)
               exp_q.push_back({(kk == nvec - 1) && (j == nb - 1), 8'(s >> (8 * j))});
         end
         if (md) for (int j = 0; j < nb; j++)
            exp_q.push_back({j == nb - 1, 8'(best >> (8 * j))});
      end

      rand_ready = rr;
      @(posedge clk); #1;
      vars = 5'(nv); free_count = 4'(fc); x0 = x; bases = b; mode = md; start = 1'b1;
      got.delete();
      lat = 0; seen = 1'b0;
      while (!seen && lat < 20000) begin
         @(posedge clk); lat++;
         if (lat == 1) begin
            #1; start = 1'b0; x0 = ~x; bases = ~b; vars = 5'd16; mode = ~md;
         end
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk({tag, ".done_seen"}, 64'(seen), 64'(1));
      if (exp_lat > 0) chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, ".err"}, 64'(err), 64'(fc > 8));
      chk({tag, ".beat_count"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         chk($sformatf("%s.beat%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
      chk({tag, ".min_weight"}, 64'(min_weight), 64'(bw));
      if (fc <= 8) chk({tag, ".min_solution"}, 64'(min_solution), 64'(best));
      chk({tag, ".solution_count"}, 64'(solution_count), 64'(nvec));
      @(negedge clk);
      chk({tag, ".done_pulse"}, 64'(done), 64'(0));
      chk({tag, ".busy_after"}, 64'(busy), 64'(0));
   endtask

   initial begin
      logic [7:0][15:0] bb;
      int               lat, nv, fc;
      logic [15:0]      xr;
      logic             md;
      bit               rr;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy", 64'(busy), 64'(0));
      chk("reset.done", 64'(done), 64'(0));
      chk("reset.err", 64'(err), 64'(0));
      chk("reset.min_weight", 64'(min_weight), 64'(31));
      chk("reset.min_solution", 64'(min_solution), 64'(0));
      chk("reset.solution_count", 64'(solution_count), 64'(0));
      chk("reset.tvalid", 64'(s_if.tvalid), 64'(0));
      rst_n = 1'b1;

      bb = '0;
      run_case("single", 5, 0, 16'b10110, bb, 1'b0, 1'b0, 0);
      bb[0] = 16'h0003; bb[1] = 16'h0004;
      run_case("all4", 4, 2, 16'h0001, bb, 1'b0, 1'b0, 0);
      run_case("min4", 4, 2, 16'h0001, bb, 1'b1, 1'b0, 6);
      bb = '0; bb[0] = 16'h000F;
      run_case("wide12", 12, 1, 16'h0ABC, bb, 1'b0, 1'b1, 0);
      run_case("err9", 4, 9, 16'h0001, bb, 1'b0, 1'b0, 1);

      rand_ready = 1'b0;
      @(posedge clk); #1;
      vars = 5'd12; free_count = 4'd1; x0 = 16'h0ABC; bases = bb; mode = 1'b0; start = 1'b1;
      got.delete();
      @(posedge clk); #1; start = 1'b0;
      lat = 0;
      while (got.size() < 1 && lat < 200) begin @(negedge clk); lat++; end
      chk("rst.first_beat", 64'(got.size()), 64'(1));
      @(posedge clk); #1; rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst.tvalid", 64'(s_if.tvalid), 64'(0));
      chk("rst.busy", 64'(busy), 64'(0));
      chk("rst.min_weight", 64'(min_weight), 64'(31));
      chk("rst.solution_count", 64'(solution_count), 64'(0));
      rst_n = 1'b1;
      run_case("rst.rerun", 12, 1, 16'h0ABC, bb, 1'b0, 1'b0, 0);

      for (int r = 0; r < 12; r++) begin
         nv = $urandom_range(1, 16);
         fc = $urandom_range(0, 6);
         xr = 16'($urandom);
         for (int i = 0; i < 8; i++) bb[i] = 16'($urandom);
         md = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         run_case($sformatf("rnd%0d", r), nv, fc, xr, bb, md, rr, 0);
      end
      run_case("err15", 16, 15, 16'hFFFF, bb, 1'b1, 1'b0, 1);
      run_case("full8", 16, 8, 16'h1234, bb, 1'b1, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
